// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the round-robin delay scheduler.
package delay_sched_pkg;
    typedef enum logic [1:0] {IDLE, COUNT, DONE} sched_state_t;

    localparam int NREQ_DEF  = 4;
    localparam int CBITS_DEF = 16;

    // Pointer to the client after ptr, wrapping at nreq.
    function automatic int rr_next(input int ptr, input int nreq);
        return (ptr + 1 >= nreq) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or after rr.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr,
    output logic            valid,
    output logic [IW-1:0]   idx
);
    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        // Walk from the far end so the closest hit to rr is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(rr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end
endmodule

// File: rtl/delay_sched.sv
// Round-robin scheduler sharing one programmable delay counter among NREQ clients.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int CBITS = CBITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  err
);
    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    sched_state_t   state;
    logic [IW-1:0]  rr, own, win;
    logic           win_vld;
    logic [CBITS-1:0] cnt, len_q;
    logic           err_nxt;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .rr    (rr),
        .valid (win_vld),
        .idx   (win)
    );

    always_comb begin
        err_nxt = 1'b0;
        if ((state == COUNT) && (cnt > len_q))     err_nxt = 1'b1;
        if ((grant & (grant - ONE)) != '0)         err_nxt = 1'b1;
        if ((done != '0) && (state != DONE))       err_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr    <= '0;
            own   <= '0;
            cnt   <= '0;
            len_q <= '0;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            err  <= err_nxt;
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state <= COUNT;
                        own   <= win;
                        len_q <= len[win*CBITS +: CBITS];
                        cnt   <= '0;
                        grant <= ONE << win;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    // Abandon wins over completion on the same edge.
                    if (!req[own]) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        rr    <= IW'(rr_next(int'(own), NREQ));
                    end else if (cnt == len_q) begin
                        state <= DONE;
                        grant <= '0;
                        done  <= ONE << own;
                    end else begin
                        cnt <= cnt + CBITS'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rr    <= IW'(rr_next(int'(own), NREQ));
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_delay_sched.sv
// Directed and randomized checks of delay_sched timing, fairness, abandon and reset.
module tb_delay_sched;
    localparam int NREQ  = 4;
    localparam int CBITS = 16;
    localparam int MAXL  = 7;
    localparam int BOUND = NREQ * (MAXL + 3) + 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CBITS-1:0] len = '0;
    logic [NREQ-1:0]       grant, done;
    logic                  busy, err;

    int tests = 0;
    int fails = 0;

    delay_sched #(.NREQ(NREQ), .CBITS(CBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .len   (len),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int client;
        int ln;
        int grant_last;   // last cycle grant is high
        int done_cyc;     // cycle of the done pulse
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [NREQ-1:0] oh, eg, ed;
        int waitc[NREQ];

        vecs[0] = '{0, 3, 4, 5};
        vecs[1] = '{2, 0, 1, 2};
        vecs[2] = '{1, 5, 6, 7};
        vecs[3] = '{3, 1, 2, 3};
        vecs[4] = '{0, 20, 21, 22};

        do_reset();
        @(negedge clk);
        check("reset_grant", grant, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);

        // Single isolated requests.
        foreach (vecs[v]) begin
            oh = '0;
            oh[vecs[v].client] = 1'b1;
            len[vecs[v].client*CBITS +: CBITS] = CBITS'(vecs[v].ln);
            req = oh;
            for (int c = 1; c <= vecs[v].done_cyc + 2; c++) begin
                @(negedge clk);
                eg = (c <= vecs[v].grant_last) ? oh : '0;
                ed = (c == vecs[v].done_cyc) ? oh : '0;
                check($sformatf("vec%0d_grant_c%0d", v, c), grant, eg);
                check($sformatf("vec%0d_done_c%0d", v, c), done, ed);
                check($sformatf("vec%0d_busy_c%0d", v, c), busy, c <= vecs[v].done_cyc);
                check($sformatf("vec%0d_err_c%0d", v, c), err, 0);
                if (c == vecs[v].done_cyc) req = '0;
            end
        end

        // Fairness: all held, len=1, done every len+3 cycles in order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NREQ; i++) len[i*CBITS +: CBITS] = 16'd1;
        req = '1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            ed = '0;
            if (c >= 3 && (c - 3) % 4 == 0) ed[((c - 3) / 4) % NREQ] = 1'b1;
            check($sformatf("fair_done_c%0d", c), done, ed);
        end
        req = '0;
        @(negedge clk);

        // Abandon: client 1 drops mid-count, pending client 3 is served next.
        do_reset();
        len[1*CBITS +: CBITS] = 16'd10;
        len[3*CBITS +: CBITS] = 16'd2;
        req = 4'b1010;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            eg = (c <= 4) ? 4'b0010 : (c >= 6 && c <= 8) ? 4'b1000 : 4'b0000;
            ed = (c == 9) ? 4'b1000 : 4'b0000;
            check($sformatf("abandon_grant_c%0d", c), grant, eg);
            check($sformatf("abandon_done_c%0d", c), done, ed);
            check($sformatf("abandon_busy_c%0d", c), busy, (c <= 4) || (c >= 6 && c <= 9));
            if (c == 4) req[1] = 1'b0;
            if (c == 9) req[3] = 1'b0;
        end

        // Asynchronous reset mid-count, then rr restarts at 0; len change during COUNT ignored.
        do_reset();
        len[0*CBITS +: CBITS] = 16'd10;
        req = 4'b0001;
        repeat (3) @(negedge clk);
        check("pre_rst_grant", grant, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_grant", grant, 0);
        check("async_rst_done", done, 0);
        check("async_rst_busy", busy, 0);
        req = 4'b1000;
        len[3*CBITS +: CBITS] = 16'd2;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            eg = (c <= 3) ? 4'b1000 : 4'b0000;
            ed = (c == 4) ? 4'b1000 : 4'b0000;
            check($sformatf("post_rst_grant_c%0d", c), grant, eg);
            check($sformatf("post_rst_done_c%0d", c), done, ed);
            if (c == 1) len[3*CBITS +: CBITS] = 16'd7;
            if (c == 4) req = '0;
        end

        // Random sweep: err stays low, held requests complete within the bound.
        do_reset();
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check("sweep_err", err, 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (done[i]) begin
                        waitc[i] = 0;
                        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    end else if ($urandom_range(0, 63) == 0) begin
                        req[i] = 1'b0;
                        waitc[i] = 0;
                    end else begin
                        waitc[i]++;
                        check($sformatf("sweep_wait_client%0d", i), waitc[i] <= BOUND, 1);
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    len[i*CBITS +: CBITS] = CBITS'($urandom_range(0, MAXL));
                    req[i] = 1'b1;
                    waitc[i] = 0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
